// File: rtl/mbf_out_pack.sv
// mbf_out_pack: tags decimator samples with channel/sequence and buffers them in a FWFT FIFO.
module mbf_out_pack #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int LEVEL_WIDTH = 5
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [DATA_WIDTH-1:0]  Data_In,
    input  logic                   Data_In_Valid,
    input  logic [3:0]             Data_In_ChIdx,
    input  logic [15:0]            Chan_Enable_Mask,
    output logic [31:0]            Data_Out,
    output logic                   Data_Out_Valid,
    input  logic                   Data_Out_Ready,
    output logic [LEVEL_WIDTH-1:0] Fifo_Level,
    output logic [15:0]            Overflow_Cnt,
    input  logic                   Overflow_Clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [31:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [3:0] seqCnt [16];
    logic [LEVEL_WIDTH-1:0] level;
    logic [23:0] sample;
    logic accept, pop, full, push, drop;
    assign sample = 24'(signed'(Data_In));
    assign accept = Data_In_Valid && Chan_Enable_Mask[Data_In_ChIdx];
    assign Data_Out_Valid = level != '0;
    assign pop = Data_Out_Valid && Data_Out_Ready;
    assign full = level == LEVEL_WIDTH'(FIFO_DEPTH);
    // a full buffer still takes the sample when the head word leaves on the same edge
    assign push = accept && (!full || pop);
    assign drop = accept && !push;
    // gating on level makes the output read as zero as soon as reset empties the buffer
    assign Data_Out = Data_Out_Valid ? mem[rdPtr] : '0;
    assign Fifo_Level = level;
    always_ff @(posedge CLK) begin
        if (push) mem[wrPtr] <= {Data_In_ChIdx, seqCnt[Data_In_ChIdx], sample};
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdPtr <= '0;
            wrPtr <= '0;
            level <= '0;
            Overflow_Cnt <= '0;
            for (int i = 0; i < 16; i++) seqCnt[i] <= '0;
        end else begin
            if (accept) seqCnt[Data_In_ChIdx] <= seqCnt[Data_In_ChIdx] + 4'd1;
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            level <= level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
            if (Overflow_Clr) Overflow_Cnt <= '0;
            else if (drop && !(&Overflow_Cnt)) Overflow_Cnt <= Overflow_Cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mbf_out_pack.sv
// tb_mbf_out_pack: directed checks of tagging, FWFT buffering, overflow and reset behaviour.
module tb_mbf_out_pack;
    logic clk = 0;
    logic nRst = 0;
    logic [23:0] dIn = '0;
    logic dValid = 0;
    logic [3:0] chIdx = '0;
    logic [15:0] mask = '0;
    logic [31:0] dOut;
    logic oValid;
    logic ready = 0;
    logic [4:0] level;
    logic [15:0] ovf;
    logic ovfClr = 0;
    logic [15:0] dIn16 = '0;
    logic dValid16 = 0;
    logic [31:0] dOut16;
    logic oValid16;
    logic [4:0] level16;
    logic [15:0] ovf16;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mbf_out_pack dut (
        .CLK(clk), .nRST(nRst), .Data_In(dIn), .Data_In_Valid(dValid), .Data_In_ChIdx(chIdx),
        .Chan_Enable_Mask(mask), .Data_Out(dOut), .Data_Out_Valid(oValid), .Data_Out_Ready(ready),
        .Fifo_Level(level), .Overflow_Cnt(ovf), .Overflow_Clr(ovfClr)
    );

    mbf_out_pack #(.DATA_WIDTH(16)) dut16 (
        .CLK(clk), .nRST(nRst), .Data_In(dIn16), .Data_In_Valid(dValid16), .Data_In_ChIdx(4'd0),
        .Chan_Enable_Mask(16'hFFFF), .Data_Out(dOut16), .Data_Out_Valid(oValid16), .Data_Out_Ready(1'b0),
        .Fifo_Level(level16), .Overflow_Cnt(ovf16), .Overflow_Clr(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ch, input logic [23:0] d);
        chIdx = ch;
        dIn = d;
        dValid = 1;
        tick();
        dValid = 0;
    endtask

    initial begin
        #2;
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_data", dOut, 0);
        chk("rst_ovf", 32'(ovf), 0);
        tick();
        tick();
        nRst = 1;
        mask = 16'hFFFF;
        ready = 1;
        send(4'd3, 24'h800001);
        chk("first_word", dOut, 32'h30800001);
        chk("first_valid", 32'(oValid), 1);
        tick();
        chk("first_gone", 32'(oValid), 0);
        chk("first_level", 32'(level), 0);

        dIn16 = 16'hFFFE;
        dValid16 = 1;
        tick();
        dValid16 = 0;
        chk("sext16", dOut16, 32'h00FFFFFE);

        ready = 0;
        for (int i = 0; i < 20; i++) send(4'd5, 24'(i));
        chk("ovf_level", 32'(level), 16);
        chk("ovf_cnt", 32'(ovf), 4);
        chk("head_seq0", dOut, {4'h5, 4'h0, 24'd0});
        tick();
        chk("head_stable", dOut, {4'h5, 4'h0, 24'd0});

        ready = 1;
        send(4'd5, 24'd20);
        chk("fullpp_level", 32'(level), 16);
        chk("fullpp_ovf", 32'(ovf), 4);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), dOut, {4'h5, 4'(i), 24'(i)});
            tick();
        end
        chk("wrap_seq4", dOut, {4'h5, 4'h4, 24'd20});
        tick();
        chk("drained", 32'(oValid), 0);

        ready = 0;
        mask = 16'h0001;
        send(4'd0, 24'h123456);
        send(4'd1, 24'hFFFFFF);
        send(4'd0, 24'h654321);
        send(4'd1, 24'hFFFFFF);
        chk("mask_level", 32'(level), 2);
        ready = 1;
        chk("mask_w0", dOut, {4'h0, 4'h0, 24'h123456});
        tick();
        chk("mask_w1", dOut, {4'h0, 4'h1, 24'h654321});
        tick();
        chk("mask_empty", 32'(level), 0);
        mask = 16'hFFFF;
        send(4'd1, 24'h000ABC);
        chk("ch1_seq0", dOut, {4'h1, 4'h0, 24'h000ABC});
        tick();
        chk("empty_ready_level", 32'(level), 0);
        tick();
        chk("empty_ready_noeffect", 32'(level), 0);

        ready = 0;
        ovfClr = 1;
        tick();
        ovfClr = 0;
        chk("clr_ovf", 32'(ovf), 0);
        for (int i = 0; i < 23; i++) send(4'd2, 24'(i));
        chk("ovf7", 32'(ovf), 7);
        ovfClr = 1;
        send(4'd2, 24'd99);
        ovfClr = 0;
        chk("clr_beats_drop", 32'(ovf), 0);
        ready = 1;
        repeat (6) tick();
        ready = 0;
        chk("ten_words", 32'(level), 10);

        @(posedge clk);
        #3;
        nRst = 0;
        #1;
        chk("async_valid", 32'(oValid), 0);
        chk("async_level", 32'(level), 0);
        chk("async_data", dOut, 0);
        tick();
        nRst = 1;
        ready = 1;
        send(4'd3, 24'h000042);
        chk("post_rst_seq0", dOut, {4'h3, 4'h0, 24'h000042});
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
